// File: rtl/huff_bit_packer_if.sv
// rtl/huff_bit_packer_if.sv - code input and packed word output bundle for the Huffman bit packer
interface huff_bit_packer_if #(
  parameter int MAX_CODE_LEN = 15
);
  logic                    code_valid;
  logic                    code_ready;
  logic [MAX_CODE_LEN-1:0] code_bits;
  logic [3:0]              code_len;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [7:0]              out_data;
  logic                    out_last;
  logic [2:0]              pad_bits;
  logic                    done;
  logic [15:0]             byte_count;

  modport master (
    output code_valid, code_bits, code_len, flush, out_ready,
    input  code_ready, out_valid, out_data, out_last, pad_bits, done, byte_count
  );

  modport slave (
    input  code_valid, code_bits, code_len, flush, out_ready,
    output code_ready, out_valid, out_data, out_last, pad_bits, done, byte_count
  );
endinterface

// File: rtl/huff_bit_packer.sv
// rtl/huff_bit_packer.sv - packs variable-length Huffman codes LSB-first into 8-bit words
module huff_bit_packer #(
  parameter int MAX_CODE_LEN = 15,
  parameter int OUT_W        = 8
) (
  input logic             clk,
  input logic             rst,
  huff_bit_packer_if.slave bus
);
  localparam int ACC_W = 7 + MAX_CODE_LEN;

  typedef enum logic [1:0] {PACK, FLUSH, DONE} state_t;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [4:0]        bit_cnt, bit_cnt_nxt;
  logic [15:0]       byte_count, byte_count_nxt, byte_count_inc;
  logic [ACC_W-1:0]  code_mask, code_ins;
  logic [8:0]        flush_mask_full;
  logic [4:0]        pad_full;
  logic              code_ready, out_valid, out_last, done;
  logic [OUT_W-1:0]  out_word;
  logic [2:0]        pad_bits;

  // Bits above code_len are masked off; acc above bit_cnt is always zero so OR inserts cleanly.
  always_comb begin
    code_mask       = (ACC_W'(1) << bus.code_len) - ACC_W'(1);
    code_ins        = (ACC_W'(bus.code_bits) & code_mask) << bit_cnt;
    flush_mask_full = (9'd1 << bit_cnt[2:0]) - 9'd1;
    pad_full        = 5'(OUT_W) - bit_cnt;
    byte_count_inc  = (byte_count == 16'hFFFF) ? byte_count : byte_count + 16'd1;
  end

  always_comb begin
    state_nxt      = state;
    acc_nxt        = acc;
    bit_cnt_nxt    = bit_cnt;
    byte_count_nxt = byte_count;
    code_ready     = 1'b0;
    out_valid      = 1'b0;
    out_word       = acc[OUT_W-1:0];
    out_last       = 1'b0;
    pad_bits       = 3'd0;
    done           = 1'b0;
    case (state)
      PACK: begin
        code_ready = (bit_cnt < 5'(OUT_W)) && !bus.flush;
        out_valid  = (bit_cnt >= 5'(OUT_W));
        if (out_valid && bus.out_ready) begin
          acc_nxt        = acc >> OUT_W;
          bit_cnt_nxt    = bit_cnt - 5'(OUT_W);
          byte_count_nxt = byte_count_inc;
        end else if (bus.code_valid && code_ready) begin
          acc_nxt     = acc | code_ins;
          bit_cnt_nxt = bit_cnt + {1'b0, bus.code_len};
        end else if (bus.flush && (bit_cnt < 5'(OUT_W))) begin
          state_nxt = (bit_cnt == 5'd0) ? DONE : FLUSH;
        end
      end
      FLUSH: begin
        out_valid = 1'b1;
        out_word  = acc[OUT_W-1:0] & flush_mask_full[OUT_W-1:0];
        out_last  = 1'b1;
        pad_bits  = pad_full[2:0];
        if (bus.out_ready) begin
          acc_nxt        = '0;
          bit_cnt_nxt    = 5'd0;
          byte_count_nxt = byte_count_inc;
          state_nxt      = DONE;
        end
      end
      DONE: begin
        done           = 1'b1;
        byte_count_nxt = 16'd0;
        state_nxt      = PACK;
      end
      default: state_nxt = PACK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PACK;
      acc        <= '0;
      bit_cnt    <= 5'd0;
      byte_count <= 16'd0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      bit_cnt    <= bit_cnt_nxt;
      byte_count <= byte_count_nxt;
    end
  end

  assign bus.code_ready = code_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_word;
  assign bus.out_last   = out_last;
  assign bus.pad_bits   = pad_bits;
  assign bus.done       = done;
  assign bus.byte_count = byte_count;
endmodule

// File: tb/tb_huff_bit_packer.sv
// tb/tb_huff_bit_packer.sv - scoreboard bench for huff_bit_packer with directed code vectors
module tb_huff_bit_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  huff_bit_packer_if #(.MAX_CODE_LEN(15)) bus ();

  huff_bit_packer #(.MAX_CODE_LEN(15), .OUT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [2:0] pad;
  } word_t;

  word_t       exp_q[$];
  logic [15:0] done_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected words and done totals as the DUT presents them.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'd0;
  word_t      w_mon;
  logic [15:0] d_mon;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        check("stall_data", {24'd0, bus.out_data}, {24'd0, prev_data});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h expected none", bus.out_data);
        end else begin
          w_mon = exp_q.pop_front();
          check("word_data", {24'd0, bus.out_data}, {24'd0, w_mon.data});
          check("word_last", {31'd0, bus.out_last}, {31'd0, w_mon.last});
          check("word_pad", {29'd0, bus.pad_bits}, {29'd0, w_mon.pad});
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else begin
          d_mon = done_q.pop_front();
          check("done_byte_count", {16'd0, bus.byte_count}, {16'd0, d_mon});
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_code(input logic [3:0] len, input logic [14:0] bits);
    bus.code_len   = len;
    bus.code_bits  = bits;
    bus.code_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.code_ready) begin
        step();
        bus.code_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got code_ready=0 expected 1");
    bus.code_valid = 1'b0;
  endtask

  task automatic end_msg();
    logic seen;
    seen     = 1'b0;
    bus.flush = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 expected 1");
    end
    step();
    bus.flush = 1'b0;
  endtask

  initial begin
    bus.code_valid = 1'b0;
    bus.code_bits  = '0;
    bus.code_len   = 4'd0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b1;

    @(negedge clk);
    check("rst_code_ready", {31'd0, bus.code_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_byte_count", {16'd0, bus.byte_count}, 32'd0);
    check("rst_last_pad", {28'd0, bus.out_last, bus.pad_bits}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // 101 then 11001 -> 0xCD; high junk bits must be ignored
    exp_q.push_back('{data: 8'hCD, last: 1'b0, pad: 3'd0});
    send_code(4'd3, 15'h7FFD);
    send_code(4'd5, 15'h7FF9);
    @(negedge clk);
    check("latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
    @(negedge clk);
    check("cd_byte_count", {16'd0, bus.byte_count}, 32'd1);
    done_q.push_back(16'd1);
    step();
    end_msg();

    // 110 then flush -> 0x06, last, pad 5
    exp_q.push_back('{data: 8'h06, last: 1'b1, pad: 3'd5});
    done_q.push_back(16'd1);
    send_code(4'd3, 15'h0006);
    end_msg();

    // 7 zeros then 15 ones with downstream stalled
    bus.out_ready = 1'b0;
    send_code(4'd7, 15'h0000);
    send_code(4'd15, 15'h7FFF);
    repeat (3) @(negedge clk);
    check("full_code_ready", {31'd0, bus.code_ready}, 32'd0);
    check("full_out_data", {24'd0, bus.out_data}, 32'h80);
    exp_q.push_back('{data: 8'h80, last: 1'b0, pad: 3'd0});
    exp_q.push_back('{data: 8'hFF, last: 1'b0, pad: 3'd0});
    exp_q.push_back('{data: 8'h3F, last: 1'b1, pad: 3'd2});
    step();
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("drained_code_ready", {31'd0, bus.code_ready}, 32'd1);
    done_q.push_back(16'd3);
    step();
    end_msg();

    // empty message with zero-length codes
    send_code(4'd0, 15'h7FFF);
    send_code(4'd0, 15'h1234);
    @(negedge clk);
    check("len0_out_valid", {31'd0, bus.out_valid}, 32'd0);
    done_q.push_back(16'd0);
    step();
    end_msg();

    // reset while the FLUSH word is stalled
    bus.out_ready = 1'b0;
    send_code(4'd3, 15'h0007);
    bus.flush = 1'b1;
    repeat (3) @(negedge clk);
    check("stalled_flush_word", {20'd0, bus.out_valid, bus.out_last, bus.pad_bits, bus.out_data},
          {20'd0, 1'b1, 1'b1, 3'd5, 8'h07});
    step();
    rst       = 1'b1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("mid_rst_outputs", {20'd0, bus.out_valid, bus.out_last, bus.pad_bits, bus.done, bus.code_ready},
          {20'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1});
    step();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    exp_q.push_back('{data: 8'h5A, last: 1'b0, pad: 3'd0});
    send_code(4'd8, 15'h005A);
    repeat (2) @(negedge clk);
    check("after_rst_byte_count", {16'd0, bus.byte_count}, 32'd1);
    done_q.push_back(16'd1);
    step();
    end_msg();

    repeat (4) step();
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("done_q_empty", done_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
